// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot sequencing, stall hold, branch/flush redirect
// with a one-deep pending branch. Optional target alignment under PC_MISALIGN_CHECK_EN.
`ifndef STOP
`define STOP 1'b1
`endif

module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STEP         = 4,
  parameter int                    STALL_WIDTH  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   branch_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  flush_target_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   ce_o,
  output logic                   redirect_pend_o,
  output logic                   misalign_o
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] LOW_M  = ADDR_WIDTH'(STEP - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  pend_q, pend_d;
  logic                  stop;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_tgt;

  assign stop = (stall_i[0] == `STOP);

  // Only stall bit 0 matters here; the rest belong to other pipeline stages.
  generate if (STALL_WIDTH > 1) begin : g_unused
    logic unused_stall;
    assign unused_stall = ^stall_i[STALL_WIDTH-1:1];
  end endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    redir     = 1'b0;
    redir_tgt = '0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (flush_i) begin
          redir     = 1'b1;
          redir_tgt = flush_target_i;
          pend_d    = 1'b0;
        end else if (branch_i && !stop) begin
          redir     = 1'b1;
          redir_tgt = branch_target_i;
          pend_d    = 1'b0;
        end else if (branch_i) begin
          // Newest stalled branch overwrites any older one.
          pend_d = 1'b1;
          tgt_d  = branch_target_i;
        end else if (pend_q && !stop) begin
          redir     = 1'b1;
          redir_tgt = tgt_q;
          pend_d    = 1'b0;
        end else if (!stop) begin
          pc_d = pc_q + STEP_A;
        end
      end
      default: state_d = BOOT;
    endcase
`ifdef PC_MISALIGN_CHECK_EN
    if (redir) pc_d = redir_tgt & ~LOW_M;
`else
    if (redir) pc_d = redir_tgt;
`endif
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) mis_q <= 1'b0;
    else          mis_q <= redir && (|(redir_tgt & LOW_M));
  end

  assign misalign_o = mis_q;
`else
  logic unused_lowm;
  assign unused_lowm = ^LOW_M;
  assign misalign_o  = 1'b0;
`endif

  assign pc_o            = pc_q;
  assign ce_o            = (state_q == RUN);
  assign redirect_pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random stall/branch/flush/reset
// traffic, all checked against a cycle-level behavioural model.
`ifndef STOP
`define STOP 1'b1
`endif

module tb_pc_gen;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        br, fl;
  logic [31:0] bt, ft;
  logic [31:0] pc;
  logic        ce, pend, mis;

  int vecs = 0;
  int errs = 0;

  // behavioural model state
  bit          m_run, m_pend, m_mis;
  logic [31:0] m_pc, m_tgt;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .STEP(STEP), .STALL_WIDTH(6)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall),
    .branch_i(br), .branch_target_i(bt),
    .flush_i(fl), .flush_target_i(ft),
    .pc_o(pc), .ce_o(ce), .redirect_pend_o(pend), .misalign_o(mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_pend = 0; m_mis = 0; m_pc = 32'h0; m_tgt = 32'h0;
  endtask

  task automatic m_go(input logic [31:0] t);
`ifdef PC_MISALIGN_CHECK_EN
    m_pc  = t - (t % STEP);
    m_mis = (t % STEP) != 0;
`else
    m_pc  = t;
`endif
  endtask

  // Model of one rising edge using the inputs currently applied.
  task automatic m_edge();
    bit stop;
    stop  = (stall[0] == `STOP);
    m_mis = 0;
    if (!m_run) begin
      m_run = 1;
    end else if (fl) begin
      m_go(ft); m_pend = 0;
    end else if (br && stop) begin
      m_pend = 1; m_tgt = bt;
    end else if (br) begin
      m_go(bt); m_pend = 0;
    end else if (m_pend && !stop) begin
      m_go(m_tgt); m_pend = 0;
    end else if (!stop) begin
      m_pc = m_pc + STEP;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},   pc,   m_pc);
    chk({tag, ".ce"},   {31'h0, ce},   {31'h0, m_run});
    chk({tag, ".pend"}, {31'h0, pend}, {31'h0, m_pend});
    chk({tag, ".mis"},  {31'h0, mis},  {31'h0, m_mis});
  endtask

  task automatic cyc(input logic [5:0] s, input logic b, input logic [31:0] btg,
                     input logic f, input logic [31:0] ftg);
    stall = s; br = b; bt = btg; fl = f; ft = ftg;
    @(posedge clk);
    m_edge();
    #1;
    chk_all("cyc");
  endtask

  task automatic idle();
    cyc(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset asserted away from any clock edge, released one edge later.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_all("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = '0; br = 0; fl = 0; bt = '0; ft = '0;
    m_reset();
    #12 chk_all("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // reset release: 0,0,4,8
    idle(); chk("boot_pc0", pc, 32'h0); chk("boot_ce", {31'h0, ce}, 32'h1);
    idle(); idle(); chk("seq8", pc, 32'h8);
    // stall holds at 8 for 3 edges, then 12
    repeat (3) cyc(6'b000001, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h8);
    idle(); chk("stall_rel", pc, 32'hC);
    // upper stall bits ignored
    cyc(6'b111110, 0, 0, 0, 0); chk("upper_stall", pc, 32'h10);
    // branch without stall
    cyc(6'b0, 1, 32'h100, 0, 0); chk("br", pc, 32'h100);
    idle(); chk("br_inc", pc, 32'h104);
    // stalled branches, newest wins
    cyc(6'b1, 1, 32'h200, 0, 0); chk("pend1", {31'h0, pend}, 32'h1);
    cyc(6'b1, 1, 32'h300, 0, 0);
    cyc(6'b1, 0, 0, 0, 0); chk("pend_hold", pc, 32'h104);
    idle(); chk("pend_take", pc, 32'h300); chk("pend_clr", {31'h0, pend}, 32'h0);
    // pending branch killed by flush
    cyc(6'b1, 1, 32'h500, 0, 0);
    cyc(6'b1, 0, 0, 1, 32'h80); chk("flush", pc, 32'h80); chk("flush_pend", {31'h0, pend}, 32'h0);
    idle(); chk("no_stale", pc, 32'h84);
    // misaligned target
    cyc(6'b0, 1, 32'h102, 0, 0);
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h100); chk("mis_pulse", {31'h0, mis}, 32'h1);
`else
    chk("mis_pc", pc, 32'h102); chk("mis_pulse", {31'h0, mis}, 32'h0);
`endif
    idle(); chk("mis_drop", {31'h0, mis}, 32'h0);
    // wrap at top of address space
    cyc(6'b0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(); chk("wrap", pc, 32'h0);
    // async reset at 0x40 with a pending branch
    cyc(6'b0, 0, 0, 1, 32'h40);
    cyc(6'b1, 1, 32'h700, 0, 0);
    do_reset();
    chk("rst_pc", pc, 32'h0); chk("rst_ce", {31'h0, ce}, 32'h0);
    idle(); idle(); chk("rst_rerun", pc, 32'h4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0]  s;
      logic        b, f;
      logic [31:0] t1, t2;
      s  = 6'($urandom);
      s[0] = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 99) < 18);
      f  = ($urandom_range(0, 99) < 6);
      t1 = $urandom; t2 = $urandom;
      if ($urandom_range(0, 3) != 0) begin t1[1:0] = 2'b00; t2[1:0] = 2'b00; end
      if ($urandom_range(0, 99) < 2) do_reset();
      else cyc(s, b, t1, f, t2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
